// File: rtl/rv_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// rv_fetch_queue_if
//   Bundles the fetch-queue control, instruction-memory and ID-stage signals.
//   master : the fetch queue (drives imem request and ID-side outputs)
//   slave  : the surrounding pipeline / memory (drives controls and rdata)
// Signals
//   PCSrc          branch taken in EX: redirect + flush
//   PC_Branch      redirect target
//   PC_write       0 = freeze fetch issue
//   IF_ID_write    ID consumes head entry this cycle
//   imem_req       fetch request issued this cycle
//   imem_addr      fetch address (= PC)
//   imem_rdata     instruction, valid one cycle after imem_req
//   ID_valid       head entry valid
//   PC_ID          PC of head instruction (0 when empty)
//   INSTRUCTION_ID head instruction (NOP when empty)
//   fifo_count     occupied entries
// ---------------------------------------------------------------------------
interface rv_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             PCSrc;
    logic [XLEN-1:0]  PC_Branch;
    logic             PC_write;
    logic             IF_ID_write;
    logic             imem_req;
    logic [XLEN-1:0]  imem_addr;
    logic [31:0]      imem_rdata;
    logic             ID_valid;
    logic [XLEN-1:0]  PC_ID;
    logic [31:0]      INSTRUCTION_ID;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        input  PCSrc, PC_Branch, PC_write, IF_ID_write, imem_rdata,
        output imem_req, imem_addr, ID_valid, PC_ID, INSTRUCTION_ID, fifo_count
    );

    modport slave (
        output PCSrc, PC_Branch, PC_write, IF_ID_write, imem_rdata,
        input  imem_req, imem_addr, ID_valid, PC_ID, INSTRUCTION_ID, fifo_count
    );
endinterface

// File: rtl/rv_fetch_queue.sv
// ---------------------------------------------------------------------------
// rv_fetch_queue
//   PC generation, synchronous instruction-memory requests and a DEPTH-entry
//   prefetch FIFO feeding the ID stage. Decouples fetch from decode stalls and
//   squashes wrong-path instructions on a branch redirect.
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   fq     rv_fetch_queue_if.master (controls, imem bus, ID-side head outputs)
// ---------------------------------------------------------------------------
module rv_fetch_queue #(
    parameter int                XLEN     = 32,
    parameter int                DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = {XLEN{1'b0}},
    parameter logic [31:0]       NOP_INSN = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    rv_fetch_queue_if.master   fq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(32'd4);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]  pc_r;
    logic [XLEN-1:0]  tag_pc_r;
    logic             inflight_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [XLEN-1:0]  fifo_pc_r   [DEPTH];
    logic [31:0]      fifo_insn_r [DEPTH];

    logic [CNT_W:0]   credit_sum_s;
    logic             issue_s;
    logic             push_s;
    logic             pop_s;
    logic             head_valid_s;
    logic [XLEN-1:0]  head_pc_s;
    logic [31:0]      head_insn_s;

    // Issue/push/pop decisions; the credit counts the in-flight slot so a
    // response can always be accepted. Reset gates issue so no request leaves
    // while state is being cleared.
    always_comb begin
        credit_sum_s = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
        issue_s      = ~reset & fq.PC_write & ~fq.PCSrc & (credit_sum_s < DEPTH_C);
        push_s       = inflight_r & ~fq.PCSrc;
        pop_s        = fq.IF_ID_write & (count_r != CNT_ZERO);
    end

    // Head-of-queue view presented to ID; a bubble when the queue is empty.
    always_comb begin
        head_valid_s = 1'b0;
        head_pc_s    = {XLEN{1'b0}};
        head_insn_s  = NOP_INSN;
        if (count_r != CNT_ZERO) begin
            head_valid_s = 1'b1;
            head_pc_s    = fifo_pc_r[rd_ptr_r];
            head_insn_s  = fifo_insn_r[rd_ptr_r];
        end else begin
            head_valid_s = 1'b0;
            head_pc_s    = {XLEN{1'b0}};
            head_insn_s  = NOP_INSN;
        end
    end

    assign fq.imem_req       = issue_s;
    assign fq.imem_addr      = pc_r;
    assign fq.ID_valid       = head_valid_s;
    assign fq.PC_ID          = head_pc_s;
    assign fq.INSTRUCTION_ID = head_insn_s;
    assign fq.fifo_count     = count_r;

    // PC, request tag, FIFO storage, pointers and occupancy; flush wins over
    // everything except reset and drops any response landing this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r       <= RESET_PC;
            tag_pc_r   <= {XLEN{1'b0}};
            inflight_r <= 1'b0;
            count_r    <= CNT_ZERO;
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_r[i]   <= {XLEN{1'b0}};
                fifo_insn_r[i] <= NOP_INSN;
            end
        end else if (fq.PCSrc) begin
            pc_r       <= fq.PC_Branch;
            tag_pc_r   <= tag_pc_r;
            inflight_r <= 1'b0;
            count_r    <= CNT_ZERO;
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                pc_r     <= pc_r + PC_STEP;
                tag_pc_r <= pc_r;
            end else begin
                pc_r     <= pc_r;
                tag_pc_r <= tag_pc_r;
            end

            if (push_s) begin
                fifo_pc_r[wr_ptr_r]   <= tag_pc_r;
                fifo_insn_r[wr_ptr_r] <= fq.imem_rdata;
                wr_ptr_r              <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end

            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end

            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule
